// File: rtl/ls_exec_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : ls_exec_unit_if
// Brief    : Issue, register-file, memory and result-bus signals of the
//            load/store execute stage.
// Revision : 1.0 - initial release
// ============================================================================
interface ls_exec_unit_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int P_W    = 5,
  parameter int TAG_W  = 5
);
  // issue side (from the load/store queue)
  logic              flush;
  logic              valid_in;
  logic              mode_in;
  logic [P_W-1:0]    Px_in;
  logic [ADDR_W-1:0] Addr_in;
  logic [TAG_W-1:0]  tag_ROB_in;
  logic              busy;
  // physical register file read port
  logic [P_W-1:0]    rd_P;
  logic [DATA_W-1:0] rd_data;
  // data memory
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  // completion broadcast
  logic              valid_Result_ls;
  logic              mode_ls;
  logic [P_W-1:0]    Pw_Result_ls;
  logic [DATA_W-1:0] Data_Result_ls;
  logic [TAG_W-1:0]  tag_ROB_Result_ls;
  logic              err_ls;

  // execute unit view
  modport master (
    input  flush, valid_in, mode_in, Px_in, Addr_in, tag_ROB_in,
    input  rd_data, mem_ready, mem_rvalid, mem_rdata,
    output busy, rd_P, mem_req, mem_we, mem_addr, mem_wdata,
    output valid_Result_ls, mode_ls, Pw_Result_ls, Data_Result_ls,
    output tag_ROB_Result_ls, err_ls
  );

  // environment view (queue, register file, memory, result consumers)
  modport slave (
    output flush, valid_in, mode_in, Px_in, Addr_in, tag_ROB_in,
    output rd_data, mem_ready, mem_rvalid, mem_rdata,
    input  busy, rd_P, mem_req, mem_we, mem_addr, mem_wdata,
    input  valid_Result_ls, mode_ls, Pw_Result_ls, Data_Result_ls,
    input  tag_ROB_Result_ls, err_ls
  );
endinterface
`default_nettype wire

// File: rtl/ls_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : ls_exec_unit
// Brief    : Load/store execute stage. Captures one issued memory op, reads
//            the store word from the PRF, performs the memory access over a
//            ready/valid handshake and broadcasts completion for one cycle.
//            A shared REQ+WAIT cycle budget turns a stuck access into an
//            error completion.
// Revision : 1.0 - initial release
// ============================================================================
module ls_exec_unit #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int P_W     = 5,
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  ls_exec_unit_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic              r_mode;
  logic [P_W-1:0]    r_px;
  logic [ADDR_W-1:0] r_addr;
  logic [TAG_W-1:0]  r_tag;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic              r_outstanding;   // accepted load whose response has not yet returned
  logic [CNT_W-1:0]  r_cnt;

  logic              w_capture;
  logic              w_take_rdata;
  logic              w_set_err;
  logic              w_set_out;
  logic              w_clr_out;
  logic              w_timeout;
  logic              w_req;
  logic              w_bcast;

  // Last budgeted cycle: without the awaited event this cycle, give up.
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

  // A flush withdraws the request in the same cycle so memory never
  // accepts an op that is being discarded.
  assign w_req   = (r_state == S_REQ) & ~bus.flush;
  assign w_bcast = (r_state == S_DONE) & ~bus.flush;

  // Freeze the queue in the very cycle an op shows up.
  assign bus.busy = ~rst & (bus.valid_in | (r_state != S_IDLE));
  assign bus.rd_P = bus.Px_in;

  assign bus.mem_req   = w_req;
  assign bus.mem_we    = w_req & ~r_mode;
  assign bus.mem_addr  = w_req ? r_addr  : '0;
  assign bus.mem_wdata = w_req ? r_wdata : '0;

  assign bus.valid_Result_ls   = w_bcast;
  assign bus.mode_ls           = w_bcast & r_mode;
  assign bus.Pw_Result_ls      = w_bcast ? r_px  : '0;
  assign bus.tag_ROB_Result_ls = w_bcast ? r_tag : '0;
  assign bus.err_ls            = w_bcast & r_err;
  assign bus.Data_Result_ls    = (w_bcast & r_mode & ~r_err) ? r_rdata : '0;

  // Next-state and datapath strobes.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_take_rdata = 1'b0;
    w_set_err    = 1'b0;
    w_set_out    = 1'b0;
    w_clr_out    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.valid_in && !bus.flush) begin
          w_capture    = 1'b1;
          w_state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.flush) begin
          w_state_next = S_IDLE;
        end else if (bus.mem_ready) begin
          if (!r_mode) begin
            w_state_next = S_DONE;
          end else if (bus.mem_rvalid) begin
            w_take_rdata = 1'b1;
            w_state_next = S_DONE;
          end else begin
            w_set_out    = 1'b1;
            w_state_next = S_WAIT;
          end
        end else if (w_timeout) begin
          w_set_err    = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_WAIT: begin
        if (bus.flush) begin
          // A response arriving with the flush settles the debt at once.
          w_clr_out    = bus.mem_rvalid;
          w_state_next = bus.mem_rvalid ? S_IDLE : S_DRAIN;
        end else if (bus.mem_rvalid) begin
          w_take_rdata = 1'b1;
          w_clr_out    = 1'b1;
          w_state_next = S_DONE;
        end else if (w_timeout) begin
          w_set_err    = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_clr_out    = bus.mem_rvalid;
        w_state_next = (r_outstanding && !bus.mem_rvalid) ? S_DRAIN : S_IDLE;
      end
      S_DRAIN: begin
        if (bus.mem_rvalid) begin
          w_clr_out    = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register and op/result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_mode        <= 1'b0;
      r_px          <= '0;
      r_addr        <= '0;
      r_tag         <= '0;
      r_wdata       <= '0;
      r_rdata       <= '0;
      r_err         <= 1'b0;
      r_outstanding <= 1'b0;
      r_cnt         <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_capture) begin
        r_mode        <= bus.mode_in;
        r_px          <= bus.Px_in;
        r_addr        <= bus.Addr_in;
        r_tag         <= bus.tag_ROB_in;
        r_wdata       <= bus.rd_data;
        r_rdata       <= '0;
        r_err         <= 1'b0;
        r_outstanding <= 1'b0;
        r_cnt         <= '0;
      end else begin
        if (r_state == S_REQ || r_state == S_WAIT) begin
          r_cnt <= r_cnt + 1'b1;
        end
        if (w_take_rdata) begin
          r_rdata <= bus.mem_rdata;
        end
        if (w_set_err) begin
          r_err <= 1'b1;
        end
        if (w_set_out) begin
          r_outstanding <= 1'b1;
        end else if (w_clr_out) begin
          r_outstanding <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ls_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ls_exec_unit
// Brief    : Self-checking bench for ls_exec_unit: a vector table of single
//            ops with a cycle-accurate memory responder, hand sequences for
//            reset/flush/back-to-back, and a result-bus scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ls_exec_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  // cycle index as seen between edges
  always @(posedge clk) cyc <= cyc + 1;

  ls_exec_unit_if bus ();

  ls_exec_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        mode;
    logic [4:0]  pw;
    logic [15:0] data;
    logic [4:0]  tag;
    logic        err;
    int          at;
  } exp_t;

  typedef struct {
    logic        mode;
    logic [4:0]  px;
    logic [15:0] addr;
    logic [4:0]  tag;
    logic [15:0] prf;
    logic [15:0] mdata;
    int          rdy;
    int          rv;
    logic [15:0] exp_data;
    logic        exp_err;
    int          lat;
    int          idle;
    int          req;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic m, input logic [4:0] px, input logic [15:0] addr,
                              input logic [4:0] tag, input logic [15:0] prf, input logic [15:0] mdata,
                              input int rdy, input int rv, input logic [15:0] ed, input logic ee,
                              input int lat, input int idle, input int req);
    vec_t v;
    v.mode = m; v.px = px; v.addr = addr; v.tag = tag; v.prf = prf; v.mdata = mdata;
    v.rdy = rdy; v.rv = rv; v.exp_data = ed; v.exp_err = ee;
    v.lat = lat; v.idle = idle; v.req = req;
    return v;
  endfunction

  // Scoreboard: every result-bus cycle is matched against the oldest expected op.
  always @(negedge clk) begin
    if (bus.valid_Result_ls) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_broadcast: got tag %0d expected none (cycle %0d)", bus.tag_ROB_Result_ls, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("result_fields",
              {4'd0, bus.mode_ls, bus.Pw_Result_ls, bus.Data_Result_ls, bus.tag_ROB_Result_ls, bus.err_ls},
              {4'd0, mon_e.mode, mon_e.pw, mon_e.data, mon_e.tag, mon_e.err});
        check("result_cycle", cyc, mon_e.at);
      end
    end else begin
      check("result_idle_zero",
            {4'd0, bus.mode_ls, bus.Pw_Result_ls, bus.Data_Result_ls, bus.tag_ROB_Result_ls, bus.err_ls}, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.flush = 1'b0; bus.valid_in = 1'b0; bus.mode_in = 1'b0; bus.Px_in = '0;
    bus.Addr_in = '0; bus.tag_ROB_in = '0; bus.rd_data = '0;
    bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 16'h0BAD;
  endtask

  task automatic issue(input logic m, input logic [4:0] px, input logic [15:0] addr,
                       input logic [4:0] tag, input logic [15:0] prf);
    bus.valid_in = 1'b1; bus.mode_in = m; bus.Px_in = px;
    bus.Addr_in = addr; bus.tag_ROB_in = tag; bus.rd_data = prf;
  endtask

  // One op with a memory that accepts after v.rdy request cycles and answers
  // loads v.rv cycles after acceptance (0 = together with acceptance).
  task automatic run_op(input vec_t v);
    int  reqcnt;
    int  hs_k;
    int  low_k;
    bit  hs;
    exp_t e;
    reqcnt = 0; hs_k = 0; low_k = -1; hs = 1'b0;
    issue(v.mode, v.px, v.addr, v.tag, v.prf);
    e.mode = v.mode; e.pw = v.px; e.data = v.exp_data; e.tag = v.tag; e.err = v.exp_err; e.at = cyc + v.lat;
    sb.push_back(e);
    @(negedge clk);
    check("busy_on_issue", {31'd0, bus.busy}, 32'd1);
    check("rd_P", {27'd0, bus.rd_P}, {27'd0, v.px});
    for (int k = 1; k <= 60; k++) begin
      tick();
      bus.valid_in   = 1'b0;
      bus.rd_data    = '0;
      bus.mem_ready  = !hs && (reqcnt == v.rdy);
      bus.mem_rvalid = v.mode && ((hs && (k - hs_k) == v.rv) || (!hs && v.rv == 0 && bus.mem_ready));
      bus.mem_rdata  = bus.mem_rvalid ? v.mdata : 16'h0BAD;
      @(negedge clk);
      if (bus.mem_req) begin
        check("req_bus", {bus.mem_we, bus.mem_addr, bus.mem_wdata},
              {~v.mode, v.addr, v.mode ? 16'h0000 : v.prf});
        reqcnt++;
        if (bus.mem_ready && !hs) begin
          hs = 1'b1;
          hs_k = k;
        end
      end else begin
        check("req_bus_idle", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, 33'd0);
      end
      if (!bus.busy) begin
        low_k = k;
        break;
      end
    end
    check("req_cycles", reqcnt, v.req);
    check("busy_low_cycle", low_k, v.idle);
    tick();
    bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 16'h0BAD;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1);
  end

  initial begin
    int t0;
    exp_t e;
    clear_inputs();

    //            mode px     addr      tag    prf       mdata    rdy rv  exp_data  err lat idle req
    vecs[0] = mk(1, 5'd7,  16'h0040, 5'd3,  16'h0000, 16'hBEEF, 0,  1,  16'hBEEF, 0,  3,  4,  1);
    vecs[1] = mk(0, 5'd5,  16'h0010, 5'd9,  16'h1234, 16'h0000, 2,  0,  16'h0000, 0,  4,  5,  3);
    vecs[2] = mk(1, 5'd2,  16'h0020, 5'd6,  16'h0000, 16'h7777, 99, 1,  16'h0000, 1,  16, 17, 15);
    vecs[3] = mk(1, 5'd11, 16'h00A0, 5'd8,  16'h0000, 16'hA5A5, 1,  0,  16'hA5A5, 0,  3,  4,  2);
    vecs[4] = mk(1, 5'd12, 16'h0B00, 5'd14, 16'h0000, 16'h3C3C, 0,  4,  16'h3C3C, 0,  6,  7,  1);
    vecs[5] = mk(0, 5'd31, 16'hFFFF, 5'd31, 16'hFFFF, 16'h0000, 0,  0,  16'h0000, 0,  2,  3,  1);
    vecs[6] = mk(1, 5'd4,  16'h0044, 5'd15, 16'h0000, 16'h5555, 0,  20, 16'h0000, 1,  16, 22, 1);
    vecs[7] = mk(1, 5'd2,  16'h0002, 5'd4,  16'h0000, 16'h1357, 0,  1,  16'h1357, 0,  3,  4,  1);
    vecs[8] = mk(0, 5'd1,  16'h8000, 5'd7,  16'h00FF, 16'h0000, 14, 0,  16'h0000, 0,  16, 17, 15);
    vecs[9] = mk(1, 5'd9,  16'h1234, 5'd12, 16'h0000, 16'hCAFE, 0,  14, 16'hCAFE, 0,  16, 17, 1);

    // reset state
    #2;
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("reset_valid_result", {31'd0, bus.valid_Result_ls}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i]);
    end

    // asynchronous reset while a request is on the bus
    issue(1'b1, 5'd3, 16'h0050, 5'd2, 16'h0000);
    tick();
    bus.valid_in = 1'b0;
    @(negedge clk);
    check("pre_reset_mem_req", {31'd0, bus.mem_req}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_outputs", {29'd0, bus.mem_req, bus.busy, bus.valid_Result_ls}, 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("after_reset_idle", {30'd0, bus.busy, bus.mem_req}, 32'd0);
    tick();

    // op arriving together with flush is discarded
    issue(1'b1, 5'd3, 16'h0060, 5'd5, 16'h0000);
    bus.flush = 1'b1;
    tick();
    clear_inputs();
    @(negedge clk);
    check("flush_on_arrival", {30'd0, bus.busy, bus.mem_req}, 32'd0);
    tick();

    // flush in WAIT: no broadcast, busy until the owed response, then a clean load
    issue(1'b1, 5'd6, 16'h0300, 5'd10, 16'h0000);
    tick();
    bus.valid_in = 1'b0;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    check("flush_wait_req", {31'd0, bus.mem_req}, 32'd1);
    tick();
    bus.mem_ready = 1'b0;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    @(negedge clk);
    check("drain_busy_1", {31'd0, bus.busy}, 32'd1);
    tick();
    @(negedge clk);
    check("drain_busy_2", {31'd0, bus.busy}, 32'd1);
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 16'hDEAD;
    @(negedge clk);
    check("drain_busy_rvalid", {30'd0, bus.busy, bus.mem_req}, 32'd2);
    tick();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = 16'h0BAD;
    @(negedge clk);
    check("drain_done_idle", {31'd0, bus.busy}, 32'd0);
    tick();
    run_op(mk(1, 5'd6, 16'h0300, 5'd11, 16'h0000, 16'h2468, 0, 1, 16'h2468, 0, 3, 4, 1));

    // flush in DONE suppresses a store's broadcast
    issue(1'b0, 5'd8, 16'h0400, 5'd13, 16'h1111);
    tick();
    bus.valid_in = 1'b0;
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_done_idle", {31'd0, bus.busy}, 32'd0);
    tick();

    // back-to-back: store held on valid_in while the load runs, taken at IDLE
    t0 = cyc;
    issue(1'b1, 5'd3, 16'h0100, 5'd1, 16'h0000);
    e.mode = 1'b1; e.pw = 5'd3; e.data = 16'h4242; e.tag = 5'd1; e.err = 1'b0; e.at = t0 + 3;
    sb.push_back(e);
    e.mode = 1'b0; e.pw = 5'd4; e.data = 16'h0000; e.tag = 5'd2; e.err = 1'b0; e.at = t0 + 6;
    sb.push_back(e);
    @(negedge clk);
    check("b2b_busy_a", {31'd0, bus.busy}, 32'd1);
    tick();
    issue(1'b0, 5'd4, 16'h0200, 5'd2, 16'h7777);
    bus.mem_ready = 1'b1;
    @(negedge clk);
    check("b2b_req_a", {bus.mem_req, bus.mem_we, bus.mem_addr}, {1'b1, 1'b0, 16'h0100});
    tick();
    bus.mem_ready = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 16'h4242;
    tick();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = 16'h0BAD;
    tick();
    @(negedge clk);
    check("b2b_busy_b", {31'd0, bus.busy}, 32'd1);
    check("b2b_rd_P", {27'd0, bus.rd_P}, 32'd4);
    tick();
    bus.valid_in = 1'b0;
    bus.rd_data = '0;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    check("b2b_req_b", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata},
          {1'b1, 1'b1, 16'h0200, 16'h7777});
    tick();
    bus.mem_ready = 1'b0;
    tick();
    @(negedge clk);
    check("b2b_idle", {31'd0, bus.busy}, 32'd0);
    tick();
    tick();

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ls_exec_unit.md
Name: ls_exec_unit

Overview:
- Load/store execute stage sitting directly downstream of the load/store queue.
- Accepts one issued memory op per transaction: mode, physical register, 16-bit address and ROB tag.
- Reads store data from the physical register file and performs the data-memory access over a ready/valid handshake.
- Broadcasts completion on the ls result bus, which wakes queue entries, ROB and issue queues; stalls the queue through busy, which drives freeze_back.

Parameters:
- DATA_W, 16, data and memory word width
- ADDR_W, 16, memory address width
- P_W, 5, physical register index width
- TAG_W, 5, ROB tag width
- TIMEOUT, 15, maximum cycles spent in REQ+WAIT before an error completion

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- flush  in  1  synchronous pipeline flush
- valid_in  in  1  issued op valid (from queue valid_op_awake)
- mode_in  in  1  1=load, 0=store
- Px_in  in  P_W  load: destination preg; store: data source preg
- Addr_in  in  ADDR_W  effective address
- tag_ROB_in  in  TAG_W  ROB tag
- busy  out  1  stall to queue (freeze_back)
- rd_P  out  P_W  PRF read index (combinational)
- rd_data  in  DATA_W  PRF read data, same cycle
- mem_req  out  1  memory request
- mem_we  out  1  1=write
- mem_addr  out  ADDR_W  request address
- mem_wdata  out  DATA_W  write data
- mem_ready  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DATA_W  read data
- valid_Result_ls  out  1  completion broadcast, one cycle
- mode_ls  out  1  mode of completing op
- Pw_Result_ls  out  P_W  preg of completing op
- Data_Result_ls  out  DATA_W  load data; 0 for store
- tag_ROB_Result_ls  out  TAG_W  ROB tag of completing op
- err_ls  out  1  completion is a timeout error, qualified by valid_Result_ls

Behaviour:
- States: IDLE, REQ, WAIT, DONE, DRAIN.
- Reset (async, rst=1): state IDLE, counter 0, all outputs 0, op registers 0.

Datapath:
- busy = valid_in | (state != IDLE); combinational so the queue is frozen in the same cycle an op arrives.
- rd_P = Px_in at all times.

Transitions:
- IDLE, valid_in=1, flush=0: latch mode, Px, Addr, tag, and rd_data as the store word; go to REQ. Counter is cleared on capture.
- valid_in while not IDLE cannot occur, because busy holds the queue; if it does, it is ignored.
- REQ: mem_req=1, mem_we=~mode, mem_addr and mem_wdata held stable until mem_ready; outputs are 0 in other states.
  - Handshake at mem_ready=1: load goes to WAIT; store goes to DONE.
  - mem_rvalid in the same cycle as mem_ready is allowed and is treated as WAIT satisfied: load goes to DONE.
- WAIT: on mem_rvalid, capture mem_rdata and go to DONE.
- Timeout: the counter increments each cycle in REQ and WAIT. When it reaches TIMEOUT without the needed event, go to DONE with err flag set and data 0.
  - A timed-out load in WAIT goes through DRAIN after DONE; see below.
- DONE: for exactly one cycle drive valid_Result_ls=1, mode_ls, Pw_Result_ls=Px, tag_ROB_Result_ls and Data_Result_ls (load data; 0 for store), and err_ls.
  - Next state is IDLE, or DRAIN if a load response is still outstanding.
  - Result outputs are 0 in every other cycle.

Latency:
- Op at queue output in cycle 0, captured at the end of cycle 0.
- With zero-wait memory (mem_ready in the REQ cycle, mem_rvalid the next cycle), a load broadcasts in cycle 3 and a store in cycle 2.
- busy is low in the cycle after DONE.

Flush (priority over everything except rst):
- IDLE/REQ: go to IDLE, drop the request, no broadcast. An op arriving with flush is discarded.
- WAIT: go to DRAIN, because a request has been accepted and a response is owed.
- DONE: suppress the broadcast, go to IDLE or DRAIN per outstanding response.
- A store already accepted by memory is not undone.
- DRAIN: busy=1, no mem_req. On mem_rvalid, discard the data and go to IDLE. No timeout in DRAIN. flush has no further effect.

Test Plan:
- Reset mid-REQ: rst=1 while mem_req=1 -> mem_req, busy, valid_Result_ls all 0 immediately (asynchronous), state IDLE.
- Zero-wait load: valid_in, mode=1, Px=7, Addr=0x0040, tag=3; mem_ready in the REQ cycle; rvalid next cycle with rdata=0xBEEF -> cycle 3: valid_Result_ls=1, mode_ls=1, Pw=7, Data=0xBEEF, tag=3, err=0; busy low in cycle 4.
- Store: Px=5, rd_data=0x1234, Addr=0x0010, mem_ready delayed 2 cycles -> mem_req held 3 cycles with we=1, addr 0x0010, wdata 0x1234 stable; one broadcast cycle with mode_ls=0, Data=0, tag as issued.
- Timeout: load, mem_ready never asserted -> after 15 cycles in REQ, a single broadcast with err_ls=1, Data=0, mem_req dropped.
- Flush in WAIT: load accepted, flush asserted, mem_rvalid 3 cycles later -> no broadcast, busy high until the rvalid cycle, then IDLE; the next load receives its own data, not the stale data.
- Back-to-back ops: queue issues load then store with busy driving freeze -> exactly two broadcasts, in order, no op lost or duplicated, busy=1 in the cycle each op arrives.
